// File: rtl/pipeline_pkg.sv
// Shared encodings for the 5-stage pipeline control path: write-back source
// select, EX operand forwarding select and the hazard controller FSM states.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WDOG_W     = 16;

    // Write-back source of an instruction; WB_LOAD marks a memory load.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

    // EX-stage operand source.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Hazard controller state.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Purely combinational EX-stage forwarding select for both source operands.
// MEM-stage results take priority over WB-stage results; x0 is never forwarded.
module hazard_fwd_unit
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_execute,
    input  logic [REG_ADDR_W-1:0] rs2_execute,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  rd_wren_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  rd_wren_wb,
    output fwd_sel_e              fwd_a_sel,
    output fwd_sel_e              fwd_b_sel
);

    function automatic fwd_sel_e select_src(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  wren_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  wren_w
    );
        fwd_sel_e sel;
        if (wren_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (wren_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Per-operand source selection.
    always_comb begin
        fwd_a_sel = select_src(rs1_execute, rd_mem, rd_wren_mem, rd_wb, rd_wren_wb);
        fwd_b_sel = select_src(rs2_execute, rd_mem, rd_wren_mem, rd_wb, rd_wren_wb);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Priority: LSU wait > EX redirect > load-use. An LSU watchdog aborts waits
// that last TIMEOUT_CYCLES MEM_WAIT cycles and pulses o_mem_timeout once.
// Optional build macro HAZARD_PERF_EN adds stall/redirect-flush counters;
// without it the counter ports are tied to zero.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs1_addr_decode,
    input  logic [4:0]       i_rs2_addr_decode,
    input  logic [4:0]       i_rs1_addr_execute,
    input  logic [4:0]       i_rs2_addr_execute,
    input  logic [4:0]       i_rd_addr_execute,
    input  logic             i_rd_wren_execute,
    input  logic [1:0]       i_wb_sel_execute,
    input  logic [4:0]       i_rd_addr_mem,
    input  logic             i_rd_wren_mem,
    input  logic [4:0]       i_rd_addr_wb,
    input  logic             i_rd_wren_wb,
    input  logic             i_pc_redirect_execute,
    input  logic             i_lsu_req_mem,
    input  logic             i_lsu_ready,
    output logic             o_stall_fetch,
    output logic             o_stall_decode,
    output logic             o_stall_mem,
    output logic             o_flush_decode,
    output logic             o_flush_execute,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_perf_stall_cnt,
    output logic [CNT_W-1:0] o_perf_flush_cnt
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    hz_state_e         state_r;
    hz_state_e         state_nxt_s;
    logic [WDOG_W-1:0] wdog_r;
    logic [WDOG_W-1:0] wdog_nxt_s;
    logic              timeout_r;
    logic              timeout_nxt_s;
    logic              mem_busy_s;
    logic              load_use_s;
    logic              redirect_flush_s;
    fwd_sel_e          fwd_a_s;
    fwd_sel_e          fwd_b_s;

    assign mem_busy_s       = i_lsu_req_mem & ~i_lsu_ready;
    assign redirect_flush_s = i_pc_redirect_execute & ~mem_busy_s;
    assign load_use_s       = i_rd_wren_execute
                            & (i_wb_sel_execute == WB_LOAD)
                            & (i_rd_addr_execute != 5'd0)
                            & ((i_rd_addr_execute == i_rs1_addr_decode) |
                               (i_rd_addr_execute == i_rs2_addr_decode));

    hazard_fwd_unit u_fwd (
        .rs1_execute (i_rs1_addr_execute),
        .rs2_execute (i_rs2_addr_execute),
        .rd_mem      (i_rd_addr_mem),
        .rd_wren_mem (i_rd_wren_mem),
        .rd_wb       (i_rd_addr_wb),
        .rd_wren_wb  (i_rd_wren_wb),
        .fwd_a_sel   (fwd_a_s),
        .fwd_b_sel   (fwd_b_s)
    );

    // FSM state, watchdog and registered timeout pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r   <= RUN;
            wdog_r    <= '0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            wdog_r    <= wdog_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    // Next state: wait for LSU ready, abort when the watchdog hits its last count.
    always_comb begin
        state_nxt_s   = state_r;
        wdog_nxt_s    = wdog_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_busy_s) begin
                    state_nxt_s = MEM_WAIT;
                    wdog_nxt_s  = '0;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (i_lsu_ready) begin
                    state_nxt_s = RUN;
                end else if (wdog_r == WDOG_LAST) begin
                    state_nxt_s   = RUN;
                    timeout_nxt_s = 1'b1;
                end else begin
                    wdog_nxt_s = wdog_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = RUN;
                wdog_nxt_s  = '0;
            end
        endcase
    end

    // Stall/flush outputs by priority; everything reads zero while reset is held.
    always_comb begin
        o_stall_fetch   = 1'b0;
        o_stall_decode  = 1'b0;
        o_stall_mem     = 1'b0;
        o_flush_decode  = 1'b0;
        o_flush_execute = 1'b0;
        if (i_reset) begin
            o_stall_fetch = 1'b0;
        end else if (mem_busy_s) begin
            o_stall_fetch  = 1'b1;
            o_stall_decode = 1'b1;
            o_stall_mem    = 1'b1;
        end else if (i_pc_redirect_execute) begin
            o_flush_decode  = 1'b1;
            o_flush_execute = 1'b1;
        end else if (load_use_s) begin
            o_stall_fetch   = 1'b1;
            o_stall_decode  = 1'b1;
            o_flush_execute = 1'b1;
        end else begin
            o_stall_fetch = 1'b0;
        end
    end

    assign o_fwd_a_sel   = i_reset ? 2'b00 : fwd_a_s;
    assign o_fwd_b_sel   = i_reset ? 2'b00 : fwd_b_s;
    assign o_mem_timeout = timeout_r;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Free-running wrap-around counters of stall cycles and redirect flushes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (o_stall_fetch) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (redirect_flush_s) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign o_perf_stall_cnt = stall_cnt_r;
    assign o_perf_flush_cnt = flush_cnt_r;
`else
    logic unused_perf_s;
    assign unused_perf_s    = redirect_flush_s;
    assign o_perf_stall_cnt = '0;
    assign o_perf_flush_cnt = '0;
`endif

endmodule
